// File: rtl/xbox_xmem_pkg.sv
// Shared constants, types and the SOC address decode for the XBOX memory responder.
package xbox_xmem_pkg;

    localparam int LINE_W     = 256;
    localparam int LINE_BYTES = 32;
    localparam int SOC_AW     = 19;
    localparam int WORD_LSB   = 2;
    localparam int LINE_LSB   = 5;

    typedef struct packed {
        logic [SOC_AW-1:0] bank;
        logic [SOC_AW-1:0] line;
        logic [2:0]        word;
        logic              oor;
    } soc_dec_t;

    // Byte address -> {bank, line, word, out_of_range}; address bits [1:0] are don't-care.
    function automatic soc_dec_t soc_decode(input logic [SOC_AW-1:0] addr,
                                            input int log2_lines,
                                            input int log2_mems);
        soc_dec_t          d;
        logic [SOC_AW-1:0] line_mask;
        logic [SOC_AW-1:0] bank_mask;
        line_mask = SOC_AW'((1 << log2_lines) - 1);
        bank_mask = SOC_AW'((1 << log2_mems) - 1);
        d.word = addr[WORD_LSB +: 3];
        d.line = (addr >> LINE_LSB) & line_mask;
        d.bank = (addr >> (LINE_LSB + log2_lines)) & bank_mask;
        d.oor  = |(addr >> (LINE_LSB + log2_lines + log2_mems));
        return d;
    endfunction

endpackage

// File: rtl/xbox_xmem_bank.sv
// One bank of 256-bit lines: single port, byte-enabled write, registered read
// that returns the line contents from before a same-cycle write.
module xbox_xmem_bank
    import xbox_xmem_pkg::*;
#(
    parameter int LOG2_LINES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LOG2_LINES-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    input  logic [LINE_BYTES-1:0] be,
    input  logic                  rd,
    input  logic                  wr,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**LOG2_LINES];

    // NOTE: storage sits in its own reset-free block; putting a memory under
    // the async reset would turn it into a huge flop array instead of a RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // NOTE: non-blocking assignment is what gives the read its pre-write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (rd) rdata <= mem[addr];
    end

endmodule

// File: rtl/xbox_xmem_resp.sv
// Memory-side responder: NUM_MEMS banks shared between the accelerator port
// (strict priority) and the SOC word port with req/gnt/rvalid handshake.
module xbox_xmem_resp
    import xbox_xmem_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int STARVE_LIMIT       = 64
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
    input  logic [NUM_MEMS-1:0][LINE_W-1:0]              xlr_mem_wdata,
    input  logic [NUM_MEMS-1:0][LINE_BYTES-1:0]          xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                          xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                          xlr_mem_wr,
    output logic [NUM_MEMS-1:0][LINE_W-1:0]              xlr_mem_rdata,
    input  logic                                         soc_req,
    input  logic                                         soc_we,
    input  logic [SOC_AW-1:0]                            soc_addr,
    input  logic [31:0]                                  soc_wdata,
    input  logic [3:0]                                   soc_be,
    output logic                                         soc_gnt,
    output logic                                         soc_rvalid,
    output logic [31:0]                                  soc_rdata,
    output logic                                         soc_err,
    output logic [SOC_AW-1:0]                            soc_xmem_wr_addr,
    output logic                                         soc_xmem_wr,
    output logic                                         soc_starved
);

    localparam int MB    = $clog2(NUM_MEMS);
    localparam int LW    = LOG2_LINES_PER_MEM;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    soc_dec_t          dec;
    logic [MB-1:0]     soc_bank;
    logic [LW-1:0]     soc_line;
    logic              soc_hit;

    logic [NUM_MEMS-1:0][LW-1:0]         b_addr;
    logic [NUM_MEMS-1:0][LINE_W-1:0]     b_wdata;
    logic [NUM_MEMS-1:0][LINE_BYTES-1:0] b_be;
    logic [NUM_MEMS-1:0]                 b_rd;
    logic [NUM_MEMS-1:0]                 b_wr;
    logic [NUM_MEMS-1:0][LINE_W-1:0]     b_rdata;

    logic [NUM_MEMS-1:0]                 acc_rd_q;
    logic [NUM_MEMS-1:0][LINE_W-1:0]     acc_hold;
    logic                                soc_rd_q;
    logic [MB-1:0]                       soc_bank_q;
    logic [2:0]                          soc_word_q;
    logic [31:0]                         soc_rdata_hold;
    logic [31:0]                         rd_word;
    logic [CNT_W-1:0]                    stall_cnt;
    logic [CNT_W-1:0]                    cnt_next;

    assign dec      = soc_decode(soc_addr, LW, MB);
    assign soc_bank = MB'(dec.bank);
    assign soc_line = LW'(dec.line);

    // Out-of-range requests never touch a bank, so they are granted immediately.
    assign soc_gnt = soc_req && (dec.oor || !(xlr_mem_rd[soc_bank] || xlr_mem_wr[soc_bank]));
    assign soc_hit = soc_gnt && !dec.oor;

    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        b_addr  = xlr_mem_addr;
        b_wdata = xlr_mem_wdata;
        b_be    = xlr_mem_be;
        b_rd    = xlr_mem_rd;
        b_wr    = xlr_mem_wr;
        if (soc_hit) begin
            b_addr[soc_bank]  = soc_line;
            b_wdata[soc_bank] = {8{soc_wdata}};
            b_be[soc_bank]    = LINE_BYTES'(soc_be) << {dec.word, 2'b00};
            b_rd[soc_bank]    = !soc_we;
            b_wr[soc_bank]    = soc_we;
        end
    end

    for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
        xbox_xmem_bank #(.LOG2_LINES(LW)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .addr  (b_addr[b]),
            .wdata (b_wdata[b]),
            .be    (b_be[b]),
            .rd    (b_rd[b]),
            .wr    (b_wr[b]),
            .rdata (b_rdata[b])
        );
        // An SOC read reuses the bank register, so the accelerator view is held separately.
        assign xlr_mem_rdata[b] = acc_rd_q[b] ? b_rdata[b] : acc_hold[b];
    end

    assign rd_word   = b_rdata[soc_bank_q][{soc_word_q, 5'b00000} +: 32];
    assign soc_rdata = soc_rd_q ? rd_word : soc_rdata_hold;

    always_comb begin
        cnt_next = '0;
        if (soc_req && !soc_gnt) begin
            cnt_next = (stall_cnt == CNT_W'(STARVE_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_rd_q         <= '0;
            acc_hold         <= '0;
            soc_rvalid       <= 1'b0;
            soc_err          <= 1'b0;
            soc_rd_q         <= 1'b0;
            soc_bank_q       <= '0;
            soc_word_q       <= '0;
            soc_rdata_hold   <= '0;
            soc_xmem_wr      <= 1'b0;
            soc_xmem_wr_addr <= '0;
            stall_cnt        <= '0;
            soc_starved      <= 1'b0;
        end else begin
            acc_rd_q <= xlr_mem_rd;
            for (int b = 0; b < NUM_MEMS; b++) begin
                if (acc_rd_q[b]) acc_hold[b] <= b_rdata[b];
            end

            soc_rvalid <= soc_gnt;
            soc_err    <= soc_gnt && dec.oor;
            soc_rd_q   <= soc_hit && !soc_we;
            if (soc_hit && !soc_we) begin
                soc_bank_q <= soc_bank;
                soc_word_q <= dec.word;
            end
            if (soc_gnt && dec.oor) soc_rdata_hold <= '0;
            else if (soc_rd_q)      soc_rdata_hold <= rd_word;

            soc_xmem_wr <= soc_hit && soc_we;
            if (soc_hit && soc_we) soc_xmem_wr_addr <= soc_addr;

            stall_cnt   <= cnt_next;
            soc_starved <= (cnt_next == CNT_W'(STARVE_LIMIT));
        end
    end

endmodule

// File: tb/tb_xbox_xmem_resp.sv
// Scoreboard bench for xbox_xmem_resp: directed stimulus pushes expectations,
// a negedge monitor pops them whenever the DUT presents a response.
module tb_xbox_xmem_resp;

    localparam int NM = 2;

    localparam logic [255:0] LANE_IDX  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    localparam logic [255:0] A5_LINE   = {8{32'hA5A5A5A5}};
    localparam logic [255:0] DEAD_LINE = {224'd0, 32'hDEADBEEF};
    localparam logic [255:0] L1_AFTER  = {192'd0, 32'h00005678, 32'd0};

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NM-1:0][7:0]         xlr_mem_addr;
    logic [NM-1:0][255:0]       xlr_mem_wdata;
    logic [NM-1:0][31:0]        xlr_mem_be;
    logic [NM-1:0]              xlr_mem_rd;
    logic [NM-1:0]              xlr_mem_wr;
    logic [NM-1:0][255:0]       xlr_mem_rdata;
    logic                       soc_req;
    logic                       soc_we;
    logic [18:0]                soc_addr;
    logic [31:0]                soc_wdata;
    logic [3:0]                 soc_be;
    logic                       soc_gnt;
    logic                       soc_rvalid;
    logic [31:0]                soc_rdata;
    logic                       soc_err;
    logic [18:0]                soc_xmem_wr_addr;
    logic                       soc_xmem_wr;
    logic                       soc_starved;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        logic [18:0] wr_addr;
        logic        chk_rdata;
    } soc_exp_t;

    soc_exp_t       soc_q[$];
    logic [255:0]   acc_q0[$];
    logic [255:0]   acc_q1[$];
    logic [NM-1:0]  acc_rd_prev;
    int             n_cmp  = 0;
    int             n_fail = 0;

    xbox_xmem_resp #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(8), .STARVE_LIMIT(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .xlr_mem_addr     (xlr_mem_addr),
        .xlr_mem_wdata    (xlr_mem_wdata),
        .xlr_mem_be       (xlr_mem_be),
        .xlr_mem_rd       (xlr_mem_rd),
        .xlr_mem_wr       (xlr_mem_wr),
        .xlr_mem_rdata    (xlr_mem_rdata),
        .soc_req          (soc_req),
        .soc_we           (soc_we),
        .soc_addr         (soc_addr),
        .soc_wdata        (soc_wdata),
        .soc_be           (soc_be),
        .soc_gnt          (soc_gnt),
        .soc_rvalid       (soc_rvalid),
        .soc_rdata        (soc_rdata),
        .soc_err          (soc_err),
        .soc_xmem_wr_addr (soc_xmem_wr_addr),
        .soc_xmem_wr      (soc_xmem_wr),
        .soc_starved      (soc_starved)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: DUT produced a response with nothing expected", name);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_rd_prev <= '0;
        else        acc_rd_prev <= xlr_mem_rd;
    end

    // Monitor: compares every DUT response against the head of its queue.
    always @(negedge clk) begin
        soc_exp_t e;
        if (rst_n) begin
            if (soc_rvalid) begin
                if (soc_q.size() == 0) unexpected("soc_rvalid");
                else begin
                    e = soc_q.pop_front();
                    check("soc_err", soc_err, e.err);
                    check("soc_xmem_wr", soc_xmem_wr, e.wr);
                    if (e.wr)        check("soc_xmem_wr_addr", soc_xmem_wr_addr, e.wr_addr);
                    if (e.chk_rdata) check("soc_rdata", soc_rdata, e.rdata);
                end
            end else if (soc_xmem_wr) begin
                unexpected("soc_xmem_wr");
            end
            if (acc_rd_prev[0]) begin
                if (acc_q0.size() == 0) unexpected("acc0_rdata");
                else check("acc0_rdata", xlr_mem_rdata[0], acc_q0.pop_front());
            end
            if (acc_rd_prev[1]) begin
                if (acc_q1.size() == 0) unexpected("acc1_rdata");
                else check("acc1_rdata", xlr_mem_rdata[1], acc_q1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_idle();
        xlr_mem_rd = '0;
        xlr_mem_wr = '0;
    endtask

    task automatic acc_set(input int b, input logic [7:0] a, input logic rd, input logic wr,
                           input logic [31:0] be, input logic [255:0] wd, input logic [255:0] exp);
        xlr_mem_addr[b]  = a;
        xlr_mem_rd[b]    = rd;
        xlr_mem_wr[b]    = wr;
        xlr_mem_be[b]    = be;
        xlr_mem_wdata[b] = wd;
        if (rd) begin
            if (b == 0) acc_q0.push_back(exp);
            else        acc_q1.push_back(exp);
        end
    endtask

    task automatic soc_set(input logic we, input logic [18:0] a, input logic [31:0] wd, input logic [3:0] be);
        soc_req   = 1'b1;
        soc_we    = we;
        soc_addr  = a;
        soc_wdata = wd;
        soc_be    = be;
    endtask

    task automatic soc_idle();
        soc_req = 1'b0;
    endtask

    task automatic push_soc(input logic [31:0] rd, input logic err, input logic wr,
                            input logic [18:0] wa, input logic chk);
        soc_exp_t e;
        e.rdata = rd; e.err = err; e.wr = wr; e.wr_addr = wa; e.chk_rdata = chk;
        soc_q.push_back(e);
    endtask

    // One SOC access on an uncontended bank; returns in the response cycle with req dropped.
    task automatic soc_txn(input logic we, input logic [18:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_rd, input logic exp_err, input logic exp_wr, input logic chk);
        tick();
        soc_set(we, a, wd, be);
        @(negedge clk);
        check("soc_gnt_free", soc_gnt, 1'b1);
        push_soc(exp_rd, exp_err, exp_wr, a, chk);
        tick();
        soc_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        xlr_mem_addr = '0; xlr_mem_wdata = '0; xlr_mem_be = '0;
        acc_idle();
        soc_req = 1'b0; soc_we = 1'b0; soc_addr = '0; soc_wdata = '0; soc_be = '0;

        repeat (3) @(negedge clk);
        check("rst_rvalid", soc_rvalid, 1'b0);
        check("rst_rdata", soc_rdata, 32'd0);
        check("rst_err", soc_err, 1'b0);
        check("rst_xmem_wr", soc_xmem_wr, 1'b0);
        check("rst_xmem_wr_addr", soc_xmem_wr_addr, 19'd0);
        check("rst_starved", soc_starved, 1'b0);
        check("rst_xlr_rdata0", xlr_mem_rdata[0], 256'd0);
        check("rst_xlr_rdata1", xlr_mem_rdata[1], 256'd0);
        rst_n = 1'b1;

        // Accelerator: fills, full-line write/read, read-before-write.
        tick(); acc_set(1, 8'd5, 0, 1, '1, A5_LINE, '0); acc_set(0, 8'd1, 0, 1, '1, '0, '0);
        tick(); acc_idle(); acc_set(0, 8'd3, 0, 1, '1, '0, '0);
        tick(); acc_idle(); acc_set(0, 8'd5, 0, 1, '1, LANE_IDX, '0);
        tick(); acc_idle(); acc_set(0, 8'd5, 1, 0, '0, '0, LANE_IDX); acc_set(1, 8'd5, 1, 0, '0, '0, A5_LINE);
        tick(); acc_idle(); acc_set(0, 8'd3, 1, 1, 32'h0000000F, DEAD_LINE, 256'd0);
        tick(); acc_idle(); acc_set(0, 8'd3, 1, 0, '0, '0, DEAD_LINE);
        tick(); acc_idle();

        // SOC write lands in bank0 line1 word1 low half; trigger follows.
        soc_txn(1'b1, 19'h0_0024, 32'h12345678, 4'b0011, 32'd0, 1'b0, 1'b1, 1'b0);
        acc_set(0, 8'd1, 1, 0, '0, '0, L1_AFTER);
        tick(); acc_idle();
        // A write with no byte enables still pulses the trigger.
        soc_txn(1'b1, 19'h0_0028, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0, 1'b1, 1'b0);
        soc_txn(1'b0, 19'h0_0024, 32'd0, 4'hF, 32'h00005678, 1'b0, 1'b0, 1'b1);
        soc_txn(1'b0, 19'h0_0028, 32'd0, 4'hF, 32'h00000000, 1'b0, 1'b0, 1'b1);

        // Starvation: accelerator holds bank0 for 70 cycles.
        for (int k = 1; k <= 70; k++) begin
            tick();
            acc_set(0, 8'd5, 1, 0, '0, '0, LANE_IDX);
            soc_set(1'b0, 19'h0_00A8, 32'd0, 4'hF);
            @(negedge clk);
            check("stall_gnt", soc_gnt, 1'b0);
            if (k == 64) check("starved_c64", soc_starved, 1'b0);
            if (k == 65) check("starved_c65", soc_starved, 1'b1);
            if (k == 70) check("starved_c70", soc_starved, 1'b1);
        end
        tick();
        acc_idle();
        @(negedge clk);
        check("release_gnt", soc_gnt, 1'b1);
        check("starved_at_release", soc_starved, 1'b1);
        push_soc(32'd2, 1'b0, 1'b0, 19'd0, 1'b1);
        tick();
        soc_idle();
        @(negedge clk);
        check("starved_cleared", soc_starved, 1'b0);
        check("acc0_hold", xlr_mem_rdata[0], LANE_IDX);

        // SOC on bank1 in parallel with accelerator read of bank0.
        tick();
        acc_set(0, 8'd3, 1, 0, '0, '0, DEAD_LINE);
        soc_set(1'b0, 19'h0_20AC, 32'd0, 4'hF);
        @(negedge clk);
        check("parallel_gnt", soc_gnt, 1'b1);
        push_soc(32'hA5A5A5A5, 1'b0, 1'b0, 19'd0, 1'b1);
        tick();
        acc_idle();
        soc_idle();

        // Out-of-range access: error response with zero data, no trigger.
        soc_txn(1'b0, 19'h4_0000, 32'd0, 4'hF, 32'd0, 1'b1, 1'b0, 1'b1);

        // Reset while a response is in flight drops it.
        tick();
        soc_set(1'b0, 19'h4_0000, 32'd0, 4'hF);
        @(negedge clk);
        check("oor2_gnt", soc_gnt, 1'b1);
        tick();
        soc_idle();
        check("rvalid_pending", soc_rvalid, 1'b1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_drop_rvalid", soc_rvalid, 1'b0);
        check("rst_drop_err", soc_err, 1'b0);
        check("rst_drop_xlr0", xlr_mem_rdata[0], 256'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        @(negedge clk);
        check("soc_q_drained", soc_q.size(), 0);
        check("acc_q0_drained", acc_q0.size(), 0);
        check("acc_q1_drained", acc_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
